// File: rtl/answer_judge.sv
// Player-side round controller: conditions switches and submit button, runs the
// seconds countdown, latches and judges the answer, and keeps score and streak.
`timescale 1ns/1ps
module answer_judge #(
    parameter int TICK_DIV      = 2000000,
    parameter int ROUND_SECS    = 3,
    parameter int DEBOUNCE      = 250000,
    parameter int RESULT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] target,
    input  logic [3:0] a,
    input  logic       pb_n,
    output logic [3:0] sec,
    output logic       busy,
    output logic       verdict_valid,
    output logic       correct,
    output logic       timeout,
    output logic [3:0] answer,
    output logic [7:0] score,
    output logic [3:0] streak
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int RW = $clog2(RESULT_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] RES_MAX   = RW'(RESULT_CYCLES - 1);
    localparam logic [3:0]    SEC_INIT  = 4'(ROUND_SECS);

    typedef enum logic [1:0] {IDLE, ARMED, JUDGE, RESULT} state_t;

    // ---------------- input conditioning ----------------
    logic [3:0] a_sync;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_a_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= a[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign a_sync[gi] = sync_reg;
        end
    endgenerate

    logic          pb_meta_reg;
    logic          pb_sync_reg;
    logic          pb_db_reg;
    logic [DW-1:0] db_cnt_reg;
    logic          db_flip;
    logic          press;

    // The flip fires on the DEBOUNCE-th consecutive cycle of the new level, so the
    // press pulse is combinational and the FSM consumes it on that same edge.
    assign db_flip = (pb_sync_reg != pb_db_reg) && (db_cnt_reg == DB_MAX);
    assign press   = db_flip && !pb_sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_meta_reg <= 1'b1;
            pb_sync_reg <= 1'b1;
            pb_db_reg   <= 1'b1;
            db_cnt_reg  <= '0;
        end else begin
            pb_meta_reg <= pb_n;
            pb_sync_reg <= pb_meta_reg;
            if (pb_sync_reg == pb_db_reg) begin
                db_cnt_reg <= '0;
            end else if (db_flip) begin
                pb_db_reg  <= pb_sync_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + DW'(1);
            end
        end
    end

    // ---------------- round FSM ----------------
    state_t        state_reg, state_next;
    logic [3:0]    target_reg, target_next;
    logic [3:0]    sec_reg, sec_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [3:0]    answer_reg, answer_next;
    logic          correct_reg, correct_next;
    logic          timeout_reg, timeout_next;
    logic [7:0]    score_reg, score_next;
    logic [3:0]    streak_reg, streak_next;
    logic [RW-1:0] res_cnt_reg, res_cnt_next;
    logic          verdict_reg, verdict_next;
    logic          busy_reg, busy_next;
    logic          tick;

    assign tick = (presc_reg == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            target_reg  <= '0;
            sec_reg     <= '0;
            presc_reg   <= '0;
            answer_reg  <= '0;
            correct_reg <= 1'b0;
            timeout_reg <= 1'b0;
            score_reg   <= '0;
            streak_reg  <= '0;
            res_cnt_reg <= '0;
            verdict_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            target_reg  <= target_next;
            sec_reg     <= sec_next;
            presc_reg   <= presc_next;
            answer_reg  <= answer_next;
            correct_reg <= correct_next;
            timeout_reg <= timeout_next;
            score_reg   <= score_next;
            streak_reg  <= streak_next;
            res_cnt_reg <= res_cnt_next;
            verdict_reg <= verdict_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        target_next  = target_reg;
        sec_next     = sec_reg;
        presc_next   = presc_reg;
        answer_next  = answer_reg;
        correct_next = correct_reg;
        timeout_next = timeout_reg;
        score_next   = score_reg;
        streak_next  = streak_reg;
        res_cnt_next = res_cnt_reg;
        verdict_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = ARMED;
                    target_next  = target;
                    sec_next     = SEC_INIT;
                    presc_next   = '0;
                    correct_next = 1'b0;
                    timeout_next = 1'b0;
                end
            end
            ARMED: begin
                presc_next = tick ? '0 : presc_reg + PW'(1);
                if (tick) begin
                    sec_next = sec_reg - 4'd1;
                end
                // A press landing on the final tick beats the timeout.
                if (press) begin
                    answer_next  = a_sync;
                    timeout_next = 1'b0;
                    state_next   = JUDGE;
                end else if (tick && (sec_reg <= 4'd1)) begin
                    answer_next  = a_sync;
                    timeout_next = 1'b1;
                    state_next   = JUDGE;
                end
            end
            JUDGE: begin
                if ((answer_reg == target_reg) && !timeout_reg) begin
                    correct_next = 1'b1;
                    if (score_reg != 8'hFF) begin
                        score_next = score_reg + 8'd1;
                    end
                    if (streak_reg != 4'hF) begin
                        streak_next = streak_reg + 4'd1;
                    end
                end else begin
                    correct_next = 1'b0;
                    streak_next  = 4'd0;
                end
                res_cnt_next = '0;
                verdict_next = 1'b1;
                state_next   = RESULT;
            end
            RESULT: begin
                if (res_cnt_reg == RES_MAX) begin
                    state_next = IDLE;
                end else begin
                    res_cnt_next = res_cnt_reg + RW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign sec           = sec_reg;
    assign busy          = busy_reg;
    assign verdict_valid = verdict_reg;
    assign correct       = correct_reg;
    assign timeout       = timeout_reg;
    assign answer        = answer_reg;
    assign score         = score_reg;
    assign streak        = streak_reg;

endmodule

// File: tb/tb_answer_judge.sv
// Self-checking bench for answer_judge: scoreboard of expected verdicts plus
// per-scenario inline checks of countdown, debounce, priority and saturation.
`timescale 1ns/1ps
module tb_answer_judge;

    localparam int TICK_DIV      = 20;
    localparam int ROUND_SECS    = 3;
    localparam int DEBOUNCE      = 4;
    localparam int RESULT_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] target;
    logic [3:0] a;
    logic       pb_n;
    logic [3:0] sec;
    logic       busy;
    logic       verdict_valid;
    logic       correct;
    logic       timeout;
    logic [3:0] answer;
    logic [7:0] score;
    logic [3:0] streak;

    always #5 clk = ~clk;

    answer_judge #(
        .TICK_DIV     (TICK_DIV),
        .ROUND_SECS   (ROUND_SECS),
        .DEBOUNCE     (DEBOUNCE),
        .RESULT_CYCLES(RESULT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .target       (target),
        .a            (a),
        .pb_n         (pb_n),
        .sec          (sec),
        .busy         (busy),
        .verdict_valid(verdict_valid),
        .correct      (correct),
        .timeout      (timeout),
        .answer       (answer),
        .score        (score),
        .streak       (streak)
    );

    typedef struct packed {
        logic       correct;
        logic       timeout;
        logic [3:0] answer;
        logic [7:0] score;
        logic [3:0] streak;
    } verdict_t;

    verdict_t exp_q[$];
    verdict_t got_v;
    verdict_t exp_v;
    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;
    int model_score  = 0;
    int model_streak = 0;

    // Reference model: advance score/streak and queue the verdict we expect.
    function automatic void push_expect(input logic [3:0] tgt, input logic [3:0] ans, input logic tmo);
        logic ok;
        ok = (tgt == ans) && !tmo;
        if (ok) begin
            if (model_score < 255) model_score++;
            if (model_streak < 15) model_streak++;
        end else begin
            model_streak = 0;
        end
        exp_q.push_back('{ok, tmo, ans, 8'(model_score), 4'(model_streak)});
    endfunction

    // Scoreboard: every verdict pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst && verdict_valid) begin
            vcount++;
            n_checks++;
            got_v = '{correct, timeout, answer, score, streak};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL verdict_unexpected: got c=%0b t=%0b ans=%0d score=%0d streak=%0d, required no verdict",
                         correct, timeout, answer, score, streak);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL verdict: got c=%0b t=%0b ans=%0d score=%0d streak=%0d, required c=%0b t=%0b ans=%0d score=%0d streak=%0d",
                             got_v.correct, got_v.timeout, got_v.answer, got_v.score, got_v.streak,
                             exp_v.correct, exp_v.timeout, exp_v.answer, exp_v.score, exp_v.streak);
                end else begin
                    $display("verdict %0d: c=%0b t=%0b ans=%0d score=%0d streak=%0d",
                             vcount, got_v.correct, got_v.timeout, got_v.answer, got_v.score, got_v.streak);
                end
            end
        end
    end

    task automatic wait_verdict(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (verdict_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_verdict_wait: got no verdict_valid in 200 cycles, required one", tag);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_idle_wait: got busy=%0b after 100 cycles, required 0", tag, busy);
        end
    endtask

    task automatic issue_start(input logic [3:0] tgt, input logic [3:0] ans);
        @(posedge clk); #1;
        a      = ans;
        target = tgt;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // One full pressed round; the press goes down 'delay' cycles after start.
    task automatic do_round(input logic [3:0] tgt, input logic [3:0] ans, input int delay);
        issue_start(tgt, ans);
        push_expect(tgt, ans, 1'b0);
        repeat (delay) @(posedge clk);
        #1 pb_n = 1'b0;
        wait_verdict("round");
        @(posedge clk); #1 pb_n = 1'b1;
        wait_idle("round");
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; target = 4'd0; a = 4'd0; pb_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sec, busy, verdict_valid, correct, timeout, answer, score, streak} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got sec=%0d busy=%0b vv=%0b c=%0b t=%0b ans=%0d score=%0d streak=%0d, required all 0",
                     sec, busy, verdict_valid, correct, timeout, answer, score, streak);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sec, busy, verdict_valid, score, streak} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_release: got sec=%0d busy=%0b vv=%0b score=%0d streak=%0d, required all 0",
                     sec, busy, verdict_valid, score, streak);
        end
    endtask

    task automatic test_correct_press;
        int v0 = vcount;
        do_round(4'd9, 4'd9, 5);
        n_checks++;
        if ({correct, timeout, answer, score, streak} !== {1'b1, 1'b0, 4'd9, 8'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL correct_press_hold: got c=%0b t=%0b ans=%0d score=%0d streak=%0d, required 1 0 9 1 1",
                     correct, timeout, answer, score, streak);
        end
        n_checks++;
        if (vcount !== v0 + 1) begin
            n_fail++;
            $display("FAIL correct_press_pulses: got %0d verdicts, required 1", vcount - v0);
        end
    endtask

    task automatic test_timeout;
        issue_start(4'd12, 4'd3);
        push_expect(4'd12, 4'd3, 1'b1);
        @(negedge clk);
        n_checks++;
        if (sec !== 4'd3) begin n_fail++; $display("FAIL timeout_sec_s0: got %0d, required 3", sec); end
        repeat (19) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sec !== 4'd3) begin n_fail++; $display("FAIL timeout_sec_s19: got %0d, required 3", sec); end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sec !== 4'd2) begin n_fail++; $display("FAIL timeout_sec_s20: got %0d, required 2", sec); end
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sec !== 4'd1) begin n_fail++; $display("FAIL timeout_sec_s40: got %0d, required 1", sec); end
        repeat (19) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sec, busy} !== {4'd1, 1'b1}) begin
            n_fail++; $display("FAIL timeout_sec_s59: got sec=%0d busy=%0b, required 1 1", sec, busy);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sec !== 4'd0) begin n_fail++; $display("FAIL timeout_sec_s60: got %0d, required 0", sec); end
        wait_verdict("timeout");
        wait_idle("timeout");
        repeat (8) @(posedge clk);
    endtask

    task automatic test_bounce;
        int v0;
        issue_start(4'd5, 4'd5);
        push_expect(4'd5, 4'd5, 1'b0);
        v0 = vcount;
        repeat (2) @(posedge clk);
        #1 pb_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 pb_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, vcount == v0} !== 2'b11) begin
            n_fail++;
            $display("FAIL bounce_short_burst: got busy=%0b verdicts=%0d, required busy=1 verdicts=0", busy, vcount - v0);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 pb_n = i[0];
        end
        @(posedge clk); #1 pb_n = 1'b0;
        wait_verdict("bounce");
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (vcount !== v0 + 1) begin
            n_fail++;
            $display("FAIL bounce_single_press: got %0d verdicts, required 1", vcount - v0);
        end
        #1 pb_n = 1'b1;
        wait_idle("bounce");
        repeat (8) @(posedge clk);
    endtask

    // Press reaches the FSM 2+DEBOUNCE edges after pb_n is first sampled low.
    task automatic test_press_at_timeout;
        issue_start(4'd7, 4'd7);
        push_expect(4'd7, 4'd7, 1'b0);
        repeat (54) @(posedge clk);
        #1 pb_n = 1'b0;
        wait_verdict("aligned");
        n_checks++;
        if ({correct, timeout} !== 2'b10) begin
            n_fail++;
            $display("FAIL aligned_press_wins: got c=%0b t=%0b, required c=1 t=0", correct, timeout);
        end
        @(posedge clk); #1 pb_n = 1'b1;
        wait_idle("aligned");
        repeat (8) @(posedge clk);

        issue_start(4'd7, 4'd7);
        push_expect(4'd7, 4'd7, 1'b1);
        repeat (55) @(posedge clk);
        #1 pb_n = 1'b0;
        wait_verdict("late");
        n_checks++;
        if ({correct, timeout} !== 2'b01) begin
            n_fail++;
            $display("FAIL late_press_timeout: got c=%0b t=%0b, required c=0 t=1", correct, timeout);
        end
        @(posedge clk); #1 pb_n = 1'b1;
        wait_idle("late");
        repeat (8) @(posedge clk);
    endtask

    task automatic test_saturation;
        logic [3:0] t;
        for (int i = 0; i < 16; i++) begin
            t = 4'($urandom_range(0, 15));
            do_round(t, t, 2);
        end
        n_checks++;
        if (streak !== 4'd15) begin n_fail++; $display("FAIL streak_saturate: got %0d, required 15", streak); end
        while (model_score < 255) begin
            t = 4'($urandom_range(0, 15));
            do_round(t, t, 2);
        end
        do_round(4'd6, 4'd6, 2);
        n_checks++;
        if ({score, streak} !== {8'd255, 4'd15}) begin
            n_fail++; $display("FAIL score_saturate: got score=%0d streak=%0d, required 255 15", score, streak);
        end
        do_round(4'd6, 4'd7, 2);
        n_checks++;
        if ({score, streak, correct} !== {8'd255, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL wrong_clears_streak: got score=%0d streak=%0d c=%0b, required 255 0 0", score, streak, correct);
        end
    endtask

    task automatic test_reset_mid_round_and_result;
        issue_start(4'd4, 4'd4);
        repeat (25) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, sec} !== {1'b1, 4'd2}) begin
            n_fail++; $display("FAIL mid_round_setup: got busy=%0b sec=%0d, required 1 2", busy, sec);
        end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, sec, score, streak} !== 17'd0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%0b sec=%0d score=%0d streak=%0d, required all 0", busy, sec, score, streak);
        end
        model_score  = 0;
        model_streak = 0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        issue_start(4'd2, 4'd2);
        push_expect(4'd2, 4'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1 pb_n = 1'b0;
        wait_verdict("result_start");
        @(posedge clk); #1 pb_n = 1'b1;
        @(posedge clk); #1 begin start = 1'b1; target = 4'd9; end
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL result_busy_held: got %0b, required 1", busy); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL result_busy_falls: got %0b, required 0", busy); end
        repeat (6) @(negedge clk);
        n_checks++;
        if ({busy, score, streak} !== {1'b0, 8'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL result_start_ignored: got busy=%0b score=%0d streak=%0d, required 0 1 1", busy, score, streak);
        end
    endtask

    initial begin
        test_reset;
        test_correct_press;
        test_timeout;
        test_bounce;
        test_press_at_timeout;
        test_saturation;
        test_reset_mid_round_and_result;
        repeat (5) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d verdicts outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/answer_judge.md
Name: answer_judge

Overview:
- Player-side counterpart to the challenge generator. The generator issues a 4-bit target and starts a round; this block runs the round.
- Within a round it synchronizes the player switches, debounces the submit button and runs the seconds countdown. It latches the player's answer on submit or timeout, compares it with the target and issues a one-cycle verdict.
- It keeps a saturating score and streak, which feed the 7-seg drivers and the buzzer tone selector.

Parameters:
TICK_DIV, 2000000, clk cycles per countdown second (bench uses 20)
ROUND_SECS, 3, countdown start value (1..15)
DEBOUNCE, 250000, consecutive stable cycles required to accept a pb_n level change (bench uses 4)
RESULT_CYCLES, 1000000, cycles the verdict is held before returning to IDLE (bench uses 8)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; a new challenge is valid
target  in  4  challenge value, sampled when start is accepted
a  in  4  raw player switches, asynchronous to clk
pb_n  in  1  raw submit button, active-low, bouncy
sec  out  4  seconds remaining
busy  out  1  high in ARMED and RESULT
verdict_valid  out  1  one-cycle pulse on entry to RESULT
correct  out  1  answer==target; held through RESULT
timeout  out  1  round ended by countdown; held through RESULT
answer  out  4  latched player answer
score  out  8  count of correct rounds, saturates at 255
streak  out  4  consecutive correct rounds, saturates at 15

Behaviour:
- Reset values: sec=0, busy=0, verdict_valid=0, correct=0, timeout=0, answer=0, score=0, streak=0. Synchronizers reset to a=0 and pb_n=1 (released). FSM resets to IDLE.
- Input conditioning:
  - a and pb_n each pass through a 2-flop synchronizer.
  - Debounced pb is initialised released. It changes only after DEBOUNCE consecutive cycles of the new synchronized level.
  - A "press" is the debounced high-to-low edge, as a 1-cycle internal pulse.
- FSM states:
  - IDLE:
    - start=1 → ARMED next cycle.
    - On that transition: latch target; sec=ROUND_SECS; clear the tick prescaler, correct and timeout.
  - ARMED:
    - The prescaler counts 0..TICK_DIV-1; at wrap, sec decrements.
    - Press → JUDGE. answer = synchronized a in the press cycle.
    - sec reaching 0 (on the prescaler wrap where sec goes 1→0) → JUDGE. answer = synchronized a in that cycle; timeout=1.
    - If press and timeout occur in the same cycle, press wins (timeout=0).
    - start is ignored.
  - JUDGE (1 cycle):
    - correct = (answer==target) AND NOT timeout. A timeout always scores as wrong.
    - On correct: score += 1 and streak += 1, both saturating.
    - Otherwise: streak = 0.
    - → RESULT. verdict_valid=1 on the first RESULT cycle only.
  - RESULT:
    - Hold correct, timeout and answer for RESULT_CYCLES cycles, then → IDLE.
    - start is ignored in RESULT.
    - sec holds its last value.
- busy=1 in ARMED, JUDGE and RESULT.
- Outputs are registered. Verdict latency: verdict_valid rises 2 cycles after the press pulse (JUDGE, then RESULT).
- Input latency: a press reaches the FSM 2 (sync) + DEBOUNCE cycles after pb_n settles.
- Reset mid-round: asynchronous return to IDLE. All outputs return to their reset values, including score and streak.
- A press while in IDLE or RESULT is discarded and not queued.

Test Plan:
1. Reset, start with target=9, a=9, clean press after 5 ticks → verdict_valid pulse once; correct=1, timeout=0, answer=9, score=1, streak=1.
2. start target=12, a=3, no press (ROUND_SECS=3, TICK_DIV=20) → sec steps 3,2,1,0 at 20-cycle intervals; JUDGE in the wrap cycle; timeout=1, correct=0, streak=0, score unchanged.
3. pb_n bounce pattern 0,1,0,1 at 1-cycle intervals then stable 0 (DEBOUNCE=4) → exactly one press accepted; bursts shorter than 4 cycles produce no press.
4. Press and final tick aligned in the same cycle with a==target → correct=1, timeout=0.
5. 16 consecutive correct rounds, then score preloaded via 255 rounds (or forced) → streak saturates at 15; score stays at 255 on a further correct round; a wrong round then gives streak=0.
6. rst asserted mid-ARMED with sec=2 → busy, sec, score and streak are 0 immediately; a start issued during RESULT is ignored and busy falls after RESULT_CYCLES.
